// File: rtl/axis_mm2s_downsizer.sv
// axis_mm2s_downsizer: splits each wide MM2S beat into two narrow AXI-Stream
// beats (lower half first). Halves with all-zero tkeep are dropped. A zero-keep
// beat carrying tlast becomes a single zero-keep tlast marker.
module axis_mm2s_downsizer #(
    parameter int unsigned SDATA_WIDTH = 256,
    parameter int unsigned MDATA_WIDTH = 128,
    parameter int unsigned KEEP_IN     = SDATA_WIDTH / 8,
    parameter int unsigned KEEP_OUT    = MDATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   CLK,
    input  logic                   resetn,
    input  logic [SDATA_WIDTH-1:0] s_axis_mm2s_tdata,
    input  logic [KEEP_IN-1:0]     s_axis_mm2s_tkeep,
    input  logic                   s_axis_mm2s_tlast,
    input  logic                   s_axis_mm2s_tvalid,
    output logic                   s_axis_mm2s_tready,
    output logic [MDATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_OUT-1:0]    m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [CNT_WIDTH-1:0]   pkt_count
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StLow   = 2'd1;
    localparam logic [1:0] StHigh  = 2'd2;
    localparam logic [1:0] StNull  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [1:0]             w_state_d;
    logic [SDATA_WIDTH-1:0] r_hold_data;
    logic [KEEP_IN-1:0]     r_hold_keep;
    logic                   r_hold_last;
    logic                   r_ready_en;
    logic [CNT_WIDTH-1:0]   r_pkt_count;

    logic                   w_hold_hi;
    logic                   w_in_lo;
    logic                   w_in_hi;
    logic [1:0]             w_load_state;
    logic                   w_m_hs;
    logic                   w_s_hs;
    logic                   w_final;

    assign w_hold_hi = |r_hold_keep[KEEP_IN-1:KEEP_OUT];
    assign w_in_lo   = |s_axis_mm2s_tkeep[KEEP_OUT-1:0];
    assign w_in_hi   = |s_axis_mm2s_tkeep[KEEP_IN-1:KEEP_OUT];

    // Output mux: EMPTY drives all zero so outputs are 0 during reset.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        case (r_state)
            StLow: begin
                m_axis_tdata  = r_hold_data[MDATA_WIDTH-1:0];
                m_axis_tkeep  = r_hold_keep[KEEP_OUT-1:0];
                m_axis_tlast  = r_hold_last && !w_hold_hi;
                m_axis_tvalid = 1'b1;
            end
            StHigh: begin
                m_axis_tdata  = r_hold_data[SDATA_WIDTH-1:MDATA_WIDTH];
                m_axis_tkeep  = r_hold_keep[KEEP_IN-1:KEEP_OUT];
                m_axis_tlast  = r_hold_last;
                m_axis_tvalid = 1'b1;
            end
            StNull: begin
                m_axis_tlast  = 1'b1;
                m_axis_tvalid = 1'b1;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    assign w_m_hs  = m_axis_tvalid && m_axis_tready;
    // Last emitted half of the held beat leaves this cycle.
    assign w_final = w_m_hs && ((r_state == StHigh) || (r_state == StNull) ||
                                ((r_state == StLow) && !w_hold_hi));

    // m_tready -> s_tready is combinational so a new beat loads with no bubble.
    assign s_axis_mm2s_tready = r_ready_en && ((r_state == StEmpty) || w_final);
    assign w_s_hs             = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
    assign pkt_count          = r_pkt_count;

    // State selected by the keep of an incoming beat.
    always_comb begin
        if (w_in_lo) begin
            w_load_state = StLow;
        end else if (w_in_hi) begin
            w_load_state = StHigh;
        end else if (s_axis_mm2s_tlast) begin
            w_load_state = StNull;
        end else begin
            w_load_state = StEmpty;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_d = r_state;
        if (w_s_hs) begin
            w_state_d = w_load_state;
        end else if (w_final) begin
            w_state_d = StEmpty;
        end else if (w_m_hs && (r_state == StLow)) begin
            w_state_d = StHigh;
        end
    end

    // State, holding register and ready enable.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StEmpty;
            r_hold_data <= '0;
            r_hold_keep <= '0;
            r_hold_last <= 1'b0;
            r_ready_en  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ready_en <= 1'b1;
            if (w_s_hs) begin
                r_hold_data <= s_axis_mm2s_tdata;
                r_hold_keep <= s_axis_mm2s_tkeep;
                r_hold_last <= s_axis_mm2s_tlast;
            end
        end
    end

    // Packet counter: one per emitted tlast, wrapping.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_pkt_count <= '0;
        end else if (w_m_hs && m_axis_tlast) begin
            r_pkt_count <= r_pkt_count + CntOne;
        end
    end

endmodule

// File: tb/tb_axis_mm2s_downsizer.sv
// Bench for axis_mm2s_downsizer: directed scenarios plus a randomized run, all
// outputs checked against a queue of expected half-beats built from input beats.
module tb_axis_mm2s_downsizer;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } in_t;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } out_t;

    logic         clk;
    logic         resetn;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic [3:0]   pkt_count;

    in_t  in_q[$];
    out_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_pkt = 0;
    int   rdy_pct = 100;
    int   cyc = 0;
    int   t_first_acc, t_first_out, t_last_out, n_out;
    logic stalled = 1'b0;
    out_t prev;

    axis_mm2s_downsizer #(
        .SDATA_WIDTH(256),
        .MDATA_WIDTH(128),
        .KEEP_IN    (32),
        .KEEP_OUT   (16),
        .CNT_WIDTH  (4)
    ) dut (
        .CLK               (clk),
        .resetn            (resetn),
        .s_axis_mm2s_tdata (s_tdata),
        .s_axis_mm2s_tkeep (s_tkeep),
        .s_axis_mm2s_tlast (s_tlast),
        .s_axis_mm2s_tvalid(s_tvalid),
        .s_axis_mm2s_tready(s_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tkeep      (m_tkeep),
        .m_axis_tlast      (m_tlast),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .pkt_count         (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] k, input logic l);
        in_t b;
        for (int i = 0; i < 8; i++) b.d[i*32 +: 32] = $urandom;
        b.k = k;
        b.l = l;
        in_q.push_back(b);
    endtask

    // Reference: a beat yields its non-empty halves in order; tlast rides on the
    // last one; a beat with no bytes at all yields only a tlast marker if tlast.
    function automatic void model_accept(input in_t b);
        logic lo, hi;
        out_t o;
        lo = (b.k[15:0] != 16'h0);
        hi = (b.k[31:16] != 16'h0);
        if (lo) begin
            o.d = b.d[127:0]; o.k = b.k[15:0]; o.l = b.l && !hi;
            exp_q.push_back(o);
        end
        if (hi) begin
            o.d = b.d[255:128]; o.k = b.k[31:16]; o.l = b.l;
            exp_q.push_back(o);
        end
        if (!lo && !hi && b.l) begin
            o.d = '0; o.k = '0; o.l = 1'b1;
            exp_q.push_back(o);
        end
    endfunction

    // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic cycle();
        out_t e;
        in_t  b;
        s_tvalid = (in_q.size() > 0);
        if (s_tvalid) begin
            b = in_q[0];
            s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l;
        end else begin
            s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        end
        m_tready = ($urandom_range(0, 99) < rdy_pct);
        @(negedge clk);
        chk("pkt_count", 256'(pkt_count), 256'(exp_pkt));
        if (stalled) begin
            chk("stall_valid", 256'(m_tvalid), 256'(1));
            chk("stall_data", 256'(m_tdata), 256'(prev.d));
            chk("stall_keep", 256'(m_tkeep), 256'(prev.k));
            chk("stall_last", 256'(m_tlast), 256'(prev.l));
        end
        if (m_tvalid && !m_tready) chk("stall_sready", 256'(s_tready), 256'(0));
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 256'(m_tvalid), 256'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 256'(m_tdata), 256'(e.d));
                chk("out_keep", 256'(m_tkeep), 256'(e.k));
                chk("out_last", 256'(m_tlast), 256'(e.l));
                if (e.l) exp_pkt = (exp_pkt + 1) % 16;
            end
            if (t_first_out < 0) t_first_out = cyc;
            t_last_out = cyc;
            n_out++;
        end
        stalled = m_tvalid && !m_tready;
        prev.d = m_tdata; prev.k = m_tkeep; prev.l = m_tlast;
        if (s_tvalid && s_tready) begin
            model_accept(in_q.pop_front());
            if (t_first_acc < 0) t_first_acc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        int save;
        n = 0;
        while ((in_q.size() + exp_q.size()) > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 256'(in_q.size() + exp_q.size()), 256'(0));
        save = rdy_pct;
        rdy_pct = 100;
        repeat (3) cycle();
        chk("idle_after_drain", 256'(m_tvalid), 256'(0));
        rdy_pct = save;
    endtask

    task automatic clear_timing();
        t_first_acc = -1; t_first_out = -1; t_last_out = -1; n_out = 0;
    endtask

    initial begin
        int n;
        resetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        m_tready = 1'b0;
        clear_timing();

        // Reset state and release.
        #12;
        chk("rst_valid", 256'(m_tvalid), 256'(0));
        chk("rst_sready", 256'(s_tready), 256'(0));
        chk("rst_data", 256'(m_tdata), 256'(0));
        #10 resetn = 1'b1;
        #1;
        chk("rel_sready_c1", 256'(s_tready), 256'(0));
        chk("rel_valid", 256'(m_tvalid), 256'(0));
        chk("rel_pkt", 256'(pkt_count), 256'(0));
        @(posedge clk);
        #1;
        chk("rel_sready_c2", 256'(s_tready), 256'(1));

        // Streaming: three full beats, tlast on the third.
        rdy_pct = 100;
        clear_timing();
        push_beat(32'hFFFFFFFF, 1'b0);
        push_beat(32'hFFFFFFFF, 1'b0);
        push_beat(32'hFFFFFFFF, 1'b1);
        drain(50);
        chk("stream_n_out", 256'(n_out), 256'(6));
        chk("stream_latency", 256'(t_first_out - t_first_acc), 256'(1));
        chk("stream_no_gap", 256'(t_last_out - t_first_out), 256'(5));
        chk("stream_pkt", 256'(pkt_count), 256'(1));

        // Partial keep.
        clear_timing();
        push_beat(32'h0000FFFF, 1'b1);
        drain(20);
        chk("lo_only_n", 256'(n_out), 256'(1));
        clear_timing();
        push_beat(32'hFFFF0000, 1'b0);
        drain(20);
        chk("hi_only_n", 256'(n_out), 256'(1));

        // Null beats.
        clear_timing();
        push_beat(32'h0, 1'b0);
        drain(20);
        chk("null_nolast_n", 256'(n_out), 256'(0));
        clear_timing();
        push_beat(32'h0, 1'b1);
        drain(20);
        chk("null_last_n", 256'(n_out), 256'(1));
        chk("null_last_pkt", 256'(pkt_count), 256'(3));

        // Backpressure while the lower half is presented.
        rdy_pct = 0;
        push_beat(32'hFFFFFFFF, 1'b0);
        push_beat(32'hFFFFFFFF, 1'b1);
        n = 0;
        while (!m_tvalid && n < 20) begin
            cycle();
            n++;
        end
        chk("bp_valid", 256'(m_tvalid), 256'(1));
        repeat (5) cycle();
        rdy_pct = 100;
        drain(50);

        // Asynchronous reset while the upper half is presented.
        push_beat(32'hFFFFFFFF, 1'b1);
        n = 0;
        while (!(in_q.size() == 0 && exp_q.size() == 1) && n < 20) begin
            cycle();
            n++;
        end
        rdy_pct = 0;
        repeat (2) cycle();
        chk("pre_rst_valid", 256'(m_tvalid), 256'(1));
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 256'(m_tvalid), 256'(0));
        chk("arst_data", 256'(m_tdata), 256'(0));
        chk("arst_keep", 256'(m_tkeep), 256'(0));
        chk("arst_last", 256'(m_tlast), 256'(0));
        chk("arst_sready", 256'(s_tready), 256'(0));
        chk("arst_pkt", 256'(pkt_count), 256'(0));
        in_q.delete();
        exp_q.delete();
        exp_pkt = 0;
        stalled = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rerel_sready", 256'(s_tready), 256'(1));

        // Counter wrap: 17 packets on a 4-bit counter.
        rdy_pct = 100;
        repeat (17) push_beat(32'hFFFFFFFF, 1'b1);
        drain(100);
        chk("wrap_pkt", 256'(pkt_count), 256'(1));

        // Randomized run with random backpressure.
        rdy_pct = 70;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] k;
            case ($urandom_range(0, 4))
                0: k = 32'hFFFFFFFF;
                1: k = 32'h0000FFFF;
                2: k = 32'hFFFF0000;
                3: k = 32'h0;
                default: k = $urandom;
            endcase
            push_beat(k, ($urandom_range(0, 2) == 0));
        end
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_mm2s_downsizer.md
# axis_mm2s_downsizer

Receives 256-bit beats from the DMA MM2S channel (16 × 16-bit samples, the same lane format the multiplier writes through S2MM). Splits each beat into two 128-bit AXI-Stream beats, lower half first, for the 128-bit sample path. Halves whose tkeep is all zero are suppressed, and packet boundaries (tlast) are preserved. Sits between the MM2S read channel and the 128-bit processing chain; full throughput is one output beat per cycle.

## Interface
- SDATA_WIDTH, 256, input beat width; must equal 2 × MDATA_WIDTH
- MDATA_WIDTH, 128, output beat width
- KEEP_IN, SDATA_WIDTH/8, input tkeep width (32)
- KEEP_OUT, MDATA_WIDTH/8, output tkeep width (16)
- CNT_WIDTH, 16, packet counter width
- CLK  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- s_axis_mm2s_tdata  in  SDATA_WIDTH  input beat; lower half = [MDATA_WIDTH-1:0]
- s_axis_mm2s_tkeep  in  KEEP_IN  byte enables
- s_axis_mm2s_tlast  in  1  end of packet
- s_axis_mm2s_tvalid  in  1  input valid
- s_axis_mm2s_tready  out  1  input ready
- m_axis_tdata  out  MDATA_WIDTH  output half-beat
- m_axis_tkeep  out  KEEP_OUT  byte enables of the emitted half
- m_axis_tlast  out  1  end of packet
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- pkt_count  out  CNT_WIDTH  count of output beats emitted with tlast; wraps

## Operation
- Holding register: hold_data, hold_keep, hold_last, loaded on an input handshake (s_tvalid && s_tready).
- States:
  - EMPTY: nothing held.
  - LOW: lower half presented.
  - HIGH: upper half presented.
  - NULL: zero-keep tlast marker presented.
- State entered on load, by the loaded beat's keep:
  - lo = keep[15:0] != 0, hi = keep[31:16] != 0.
  - lo → LOW; !lo && hi → HIGH.
  - !lo && !hi && last → NULL; !lo && !hi && !last → beat discarded, stay/return EMPTY.
- Output content:
  - LOW: m_tdata = hold_data[127:0], m_tkeep = hold_keep[15:0].
  - HIGH: m_tdata = hold_data[255:128], m_tkeep = hold_keep[31:16].
  - NULL: m_tdata = 0, m_tkeep = 0, m_tlast = 1.
- m_tlast is asserted only on the final emitted half of a beat with hold_last = 1:
  - on LOW when hi = 0;
  - on HIGH always when hold_last = 1;
  - on NULL always.
- m_tvalid = 1 in LOW, HIGH and NULL; 0 in EMPTY.
- Transitions on an output handshake (m_tvalid && m_tready):
  - LOW → HIGH if hi, else the final half has been consumed.
  - HIGH or NULL → the final half has been consumed.
- Final half consumed: if an input handshake occurs in the same cycle, go to the state the new beat selects (no bubble); otherwise go to EMPTY.
- s_tready = ready_en && (state == EMPTY || final half consumed this cycle). The combinational path from m_tready to s_tready is intended.
- pkt_count increments by 1 on every output handshake with m_tlast = 1 and wraps from 2^CNT_WIDTH−1 to 0.
- No data arithmetic; lanes are passed through bit-exact.

## Timing
- resetn low (asynchronous): state = EMPTY, all hold registers 0, ready_en = 0, pkt_count = 0.
- Outputs during reset: m_tvalid = 0, m_tdata = 0, m_tkeep = 0, m_tlast = 0, s_tready = 0.
- ready_en sets on the first CLK edge after resetn deasserts, so s_tready rises one cycle after release.
- Reset mid-packet: the held beat is discarded and no tlast is emitted. Upstream must restart the packet.
- Latency: the input beat accepted at edge N appears on m_axis in cycle N+1.
- Throughput: a full beat takes 2 output cycles; with continuous valid/ready, s_tready pulses every 2nd cycle and m_tvalid stays high.
- Backpressure: while m_tready = 0, m_tdata, m_tkeep and m_tlast hold stable and s_tready = 0 unless state = EMPTY.
- Once asserted, m_tvalid stays high until the handshake.
- tkeep patterns are not checked for contiguity.

## Test plan
- Reset release: resetn 0→1 → s_tready = 0 in the first cycle, 1 in the second; m_tvalid = 0; pkt_count = 0.
- Streaming: three beats, keep = 32'hFFFFFFFF, tlast on the third, m_tready = 1 → six output beats, each keep = 16'hFFFF, halves in order lo0, hi0, lo1, hi1, lo2, hi2; tlast only on hi2; no idle cycle between outputs; pkt_count = 1.
- Partial keep:
  - keep = 32'h0000FFFF with tlast → one beat, lower half, tlast = 1.
  - keep = 32'hFFFF0000 → one beat, upper half, keep = 16'hFFFF.
- Null beats:
  - keep = 0, tlast = 0 → no output.
  - keep = 0, tlast = 1 → one beat with tdata = 0, tkeep = 0, tlast = 1; pkt_count increments.
- Backpressure: hold m_tready = 0 for 5 cycles while in LOW → output stable, s_tready = 0; then release → remaining halves emitted in order with no loss or duplication.
- Counter wrap and reset:
  - CNT_WIDTH = 4, 17 packets → pkt_count = 1.
  - Assert resetn = 0 while in HIGH → outputs go to 0 immediately, without waiting for a CLK edge.
